// File: rtl/pm_lcd_pkg.sv
// Shared LCD register-bus constants and the frame-copier state encoding.
package pm_lcd_pkg;

    localparam logic [23:0] LCD_CMD_ADDR  = 24'h0020FE;
    localparam logic [23:0] LCD_DATA_ADDR = 24'h0020FF;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_HI,
        ST_CMD_LO,
        ST_FETCH,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_DONE
    } copier_state_e;

    // Page-setup command byte for step idx of the three-command preamble.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [3:0] page);
        case (idx)
            2'd0:    cmd_byte = CMD_SET_PAGE | {4'h0, page};
            2'd1:    cmd_byte = CMD_COL_LO;
            default: cmd_byte = CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_strobe.sv
// Single-cycle LCD write strobe: a request fires only when the CPU is not holding
// the bus, and a strobe once raised always drops on the following clk_ce cycle.
module lcd_bus_strobe (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        req,
    input  logic        cpu_hold,
    input  logic [23:0] addr_in,
    input  logic [7:0]  data_in,
    output logic        fire,
    output logic        lcd_write,
    output logic [23:0] lcd_addr,
    output logic [7:0]  lcd_data
);

    logic        write_q, write_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    // Gating on write_q guarantees a low cycle between strobes.
    assign fire = clk_ce & req & ~cpu_hold & ~write_q;

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clk_ce) begin
            write_d = fire;
            if (fire) begin
                addr_d = addr_in;
                data_d = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign lcd_write = write_q;
    assign lcd_addr  = addr_q;
    assign lcd_data  = data_q;

endmodule

// File: rtl/lcd_frame_copier.sv
// Copies a paged 1bpp framebuffer from RAM into the LCD controller, page by page,
// sharing the LCD register bus with the CPU.
module lcd_frame_copier
    import pm_lcd_pkg::*;
#(
    parameter logic [23:0] FB_BASE = 24'h001000,
    parameter int          COLUMNS = 96,
    parameter int          PAGES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        start,
    input  logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        lcd_write,
    output logic [23:0] lcd_addr,
    output logic [7:0]  lcd_data
);

    localparam logic [6:0] COL_LAST  = 7'(COLUMNS - 1);
    localparam logic [3:0] PAGE_LAST = 4'(PAGES - 1);

    copier_state_e state_q, state_d;
    logic [3:0]  page_q, page_d;
    logic [6:0]  col_q, col_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [7:0]  pix_q, pix_d;

    logic        strobe_req, strobe_fire;
    logic [23:0] strobe_addr;
    logic [7:0]  strobe_data;

    function automatic logic [23:0] fb_addr(input logic [3:0] page, input logic [6:0] col);
        fb_addr = FB_BASE + 24'(page) * 24'(COLUMNS) + 24'(col);
    endfunction

    assign strobe_req  = (state_q == ST_CMD_HI) || (state_q == ST_DATA_HI);
    assign strobe_addr = (state_q == ST_DATA_HI) ? LCD_DATA_ADDR : LCD_CMD_ADDR;
    assign strobe_data = (state_q == ST_DATA_HI) ? pix_q : cmd_byte(cmd_idx_q, page_q);

    lcd_bus_strobe u_strobe (
        .clk       (clk),
        .reset     (reset),
        .clk_ce    (clk_ce),
        .req       (strobe_req),
        .cpu_hold  (cpu_hold),
        .addr_in   (strobe_addr),
        .data_in   (strobe_data),
        .fire      (strobe_fire),
        .lcd_write (lcd_write),
        .lcd_addr  (lcd_addr),
        .lcd_data  (lcd_data)
    );

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        cmd_idx_d  = cmd_idx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pix_d      = pix_q;
        if (clk_ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_CMD_HI;
                        page_d    = '0;
                        col_d     = '0;
                        cmd_idx_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                ST_CMD_HI: begin
                    if (strobe_fire) state_d = ST_CMD_LO;
                end
                ST_CMD_LO: begin
                    if (cmd_idx_q == 2'd2) begin
                        col_d      = '0;
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fb_addr(page_q, 7'd0);
                    end else begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                        state_d   = ST_CMD_HI;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        pix_d     = mem_data;
                        mem_req_d = 1'b0;
                        state_d   = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (strobe_fire) state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    if (col_q < COL_LAST) begin
                        col_d      = col_q + 7'd1;
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fb_addr(page_q, col_q + 7'd1);
                    end else if (page_q < PAGE_LAST) begin
                        page_d    = page_q + 4'd1;
                        cmd_idx_d = '0;
                        state_d   = ST_CMD_HI;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    // Reset acts on every clk edge, independent of clk_ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            page_q     <= '0;
            col_q      <= '0;
            cmd_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            col_q      <= col_d;
            cmd_idx_q  <= cmd_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pix_q      <= pix_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_lcd_frame_copier.sv
// Scoreboard bench for lcd_frame_copier: expected LCD writes are queued per frame
// and popped as strobes appear on the LCD bus.
module tb_lcd_frame_copier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ce = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold = 1'b0;
    logic        busy, done, mem_req, mem_ack, lcd_write;
    logic [23:0] mem_addr, lcd_addr;
    logic [7:0]  mem_data, lcd_data;

    int tests = 0;
    int fails = 0;
    int ce_div = 1;
    int ce_ctr = 0;
    int mem_delay = 0;
    int wait_cnt = 0;
    int n_writes = 0;
    int n_done = 0;
    int n_busy = 0;
    bit prev_write = 1'b0;
    logic [31:0] exp_q[$];

    lcd_frame_copier dut (
        .clk       (clk),
        .reset     (reset),
        .clk_ce    (clk_ce),
        .start     (start),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .lcd_write (lcd_write),
        .lcd_addr  (lcd_addr),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ce_ctr = ce_ctr + 1;
        clk_ce = ((ce_ctr % ce_div) == 0);
    end

    // RAM model: byte at address a reads as a[7:0]; ack after mem_delay wait cycles.
    assign mem_ack  = mem_req && (wait_cnt >= mem_delay);
    assign mem_data = mem_addr[7:0];

    always @(posedge clk) begin
        if (clk_ce) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (!reset && clk_ce) begin
            if (lcd_write) begin
                logic [31:0] e;
                n_writes++;
                tests++;
                if (prev_write) begin
                    fails++;
                    $display("FAIL strobe_consecutive write#%0d: lcd_write=1 on two clk_ce cycles in a row", n_writes);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_extra write#%0d: got %h/%h, none expected", n_writes, lcd_addr, lcd_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({lcd_addr, lcd_data} !== e) begin
                        fails++;
                        $display("FAIL write_seq write#%0d: got %h/%h, expected %h/%h",
                                 n_writes, lcd_addr, lcd_data, e[31:8], e[7:0]);
                    end
                end
                if (mem_req) begin
                    fails++;
                    $display("FAIL fetch_write write#%0d: lcd_write while mem_req=1", n_writes);
                end
            end
            if (done) n_done++;
            if (busy) n_busy++;
            prev_write = lcd_write;
        end
    end

    task automatic start_frame();
        logic [23:0] a;
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({24'h0020FE, 8'hB0 + 8'(p)});
            exp_q.push_back({24'h0020FE, 8'h00});
            exp_q.push_back({24'h0020FE, 8'h10});
            for (int c = 0; c < 96; c++) begin
                a = 24'h001000 + 24'(p * 96 + c);
                exp_q.push_back({24'h0020FF, a[7:0]});
            end
        end
        n_writes = 0;
        n_done = 0;
        n_busy = 0;
        do @(negedge clk); while (!clk_ce);
        #1 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_busy, input string name);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (n_done == 0) begin
            fails++;
            $display("FAIL %s_timeout: no done within %0d clocks", name, budget);
        end
        repeat (4 * ce_div + 2) @(negedge clk);
        tests++;
        if (n_done !== 1) begin
            fails++;
            $display("FAIL %s_done_count: got %0d clk_ce cycles of done, expected 1", name, n_done);
        end
        tests++;
        if (n_writes !== 792) begin
            fails++;
            $display("FAIL %s_write_count: got %0d strobes, expected 792", name, n_writes);
        end
        tests++;
        if (n_busy !== exp_busy) begin
            fails++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, n_busy, exp_busy);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_missing_writes: %0d expected writes never seen", name, exp_q.size());
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_busy: busy=%b after frame, expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
        tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        tests++; if (mem_addr !== 24'h0) begin fails++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        tests++; if (lcd_write !== 1'b0) begin fails++; $display("FAIL rst_lcd_write: got %b expected 0", lcd_write); end
        tests++; if (lcd_addr !== 24'h0) begin fails++; $display("FAIL rst_lcd_addr: got %h expected 0", lcd_addr); end
        tests++; if (lcd_data !== 8'h0)  begin fails++; $display("FAIL rst_lcd_data: got %h expected 0", lcd_data); end
        // start alongside reset must be ignored
        start = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_start_busy: got %b expected 0", busy); end
    endtask

    task automatic test_zero_wait(input string name);
        mem_delay = 0;
        start_frame();
        wait_done(6000, 2353, name);
    endtask

    task automatic test_slow_mem();
        mem_delay = 3;
        start_frame();
        wait_done(12000, 8 * 582 + 1, "slow_mem");
        mem_delay = 0;
    endtask

    task automatic test_cpu_hold();
        int k = 0;
        int cnt = 0;
        bit found = 1'b0;
        start_frame();
        while (!found && k < 6000) begin
            @(negedge clk);
            k++;
            if (clk_ce && mem_ack && mem_addr == 24'h001000 + 24'd328) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL hold_trigger: fetch of page 3 col 40 not seen");
        end else begin
            @(posedge clk);
            #2 cpu_hold = 1'b1;
            while (cnt < 10) begin
                @(negedge clk);
                if (clk_ce) begin
                    cnt++;
                    tests++;
                    if (lcd_write !== 1'b0) begin
                        fails++;
                        $display("FAIL hold_write cycle %0d: lcd_write=%b expected 0", cnt, lcd_write);
                    end
                end
            end
            @(posedge clk);
            #2 cpu_hold = 1'b0;
        end
        wait_done(6000, 2363, "cpu_hold");
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bit found = 1'b0;
        start_frame();
        while (!found && k < 6000) begin
            @(negedge clk);
            k++;
            if (clk_ce && lcd_write && n_writes >= 5 * 99 + 10) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL midrst_trigger: page 5 strobe not seen");
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        tests++; if (lcd_write !== 1'b0) begin fails++; $display("FAIL midrst_write: got %b expected 0", lcd_write); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL midrst_mem_req: got %b expected 0", mem_req); end
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        test_zero_wait("restart");
    endtask

    task automatic test_start_spam();
        mem_delay = 0;
        start_frame();
        fork
            begin
                repeat (400) begin
                    @(posedge clk);
                    #3 start = 1'($urandom_range(0, 1));
                end
                start = 1'b0;
            end
        join_none
        wait_done(6000, 2353, "start_spam");
    endtask

    task automatic test_ce_div();
        ce_div = 4;
        repeat (8) @(posedge clk);
        start_frame();
        wait_done(12000, 2353, "ce_div");
        ce_div = 1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait("zero_wait");
        test_slow_mem();
        test_cpu_hold();
        test_reset_mid();
        test_start_spam();
        test_ce_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
